// File: rtl/irq_pkg.sv
// Shared types and helpers for the external-interrupt gateway.
package irq_pkg;

  // Largest source count the claim ID encoding is sized for.
  localparam int MAX_SRC = 31;

  // Request/claim handshake states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Claim IDs are 1-based so that 0 can mean "nothing claimed".
  function automatic int id_of(input int index);
    return index + 1;
  endfunction

endpackage

// File: rtl/irq_prio_arb.sv
// Combinational winner selection among eligible interrupt sources.
// Fixed mode scans upward from index 0; rotating mode scans upward from the
// index just after the last claimed source, wrapping modulo NUM_SRC.
module irq_prio_arb
  import irq_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int ROUND_ROBIN = 0,
  parameter int IDX_W       = 3
) (
  input  logic [NUM_SRC-1:0] i_eligible,
  input  logic [IDX_W-1:0]   i_last_claim,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_valid
);

  int               w_start;
  logic [IDX_W-1:0] w_idx;

  // Scan from the far end back toward the start so the first eligible index
  // after the starting point is the last one written, hence the winner.
  always_comb begin
    w_start  = 0;
    w_idx    = '0;
    o_winner = '0;
    if (ROUND_ROBIN != 0) begin
      w_start = (int'(i_last_claim) + 1) % NUM_SRC;
    end
    for (int off = NUM_SRC - 1; off >= 0; off--) begin
      w_idx = IDX_W'((w_start + off) % NUM_SRC);
      if (i_eligible[w_idx]) begin
        o_winner = w_idx;
      end
    end
  end

  assign o_valid = |i_eligible;

endmodule

// File: rtl/irq_gateway.sv
// Multi-source external-interrupt gateway: per-source edge/level capture,
// priority arbitration, meip request and claim/complete handshake.
module irq_gateway
  import irq_pkg::*;
#(
  parameter  int NUM_SRC     = 8,
  parameter  int ROUND_ROBIN = 0,
  localparam int ID_W        = $clog2(NUM_SRC + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] mode_i,
  input  logic [NUM_SRC-1:0] enable_i,
  output logic               meip_o,
  input  logic               irq_ack_i,
  output logic [ID_W-1:0]    claim_id_o,
  input  logic               complete_i,
  output logic [NUM_SRC-1:0] pending_o
);

  localparam int               IDX_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_SRC - 1);

  state_t             r_state;
  logic               r_meip;
  logic [ID_W-1:0]    r_claim_id;
  logic [NUM_SRC-1:0] r_in_service;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_src_q;
  logic [IDX_W-1:0]   r_last_claim;

  logic [NUM_SRC-1:0] w_eligible;
  logic [NUM_SRC-1:0] w_pending_next;
  logic [NUM_SRC-1:0] w_clear;
  logic [IDX_W-1:0]   w_winner;
  logic               w_valid;
  logic               w_claim;

  // A source in service never competes again until it is completed.
  assign w_eligible = r_pending & enable_i & ~r_in_service;

  irq_prio_arb #(
    .NUM_SRC    (NUM_SRC),
    .ROUND_ROBIN(ROUND_ROBIN),
    .IDX_W      (IDX_W)
  ) u_arb (
    .i_eligible  (w_eligible),
    .i_last_claim(r_last_claim),
    .o_winner    (w_winner),
    .o_valid     (w_valid)
  );

  // The claim takes whatever winner the arbiter shows in the ack cycle.
  assign w_claim = (r_state == REQ) && irq_ack_i && w_valid;

  // Per-source gateway: edge sources latch until claimed (a fresh edge in the
  // claim cycle wins over the clear); level sources track the line but are
  // held low while that same source is being serviced.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign w_clear[gi] = w_claim && (w_winner == IDX_W'(gi));
      assign w_pending_next[gi] = mode_i[gi]
          ? ((r_pending[gi] & ~w_clear[gi]) | (src_i[gi] & ~r_src_q[gi]))
          : (src_i[gi] & ~r_in_service[gi]);
    end
  endgenerate

  // Source history and pending capture.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_src_q   <= '0;
      r_pending <= '0;
    end else begin
      r_src_q   <= src_i;
      r_pending <= w_pending_next;
    end
  end

  // Request/claim/complete handshake with registered meip and claim ID.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state      <= IDLE;
      r_meip       <= 1'b0;
      r_claim_id   <= '0;
      r_in_service <= '0;
      r_last_claim <= LAST_RESET;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_eligible) begin
            r_state <= REQ;
            r_meip  <= 1'b1;
          end
        end
        REQ: begin
          if (w_claim) begin
            r_state      <= SERVICE;
            r_meip       <= 1'b0;
            r_claim_id   <= ID_W'(id_of(int'(w_winner)));
            r_in_service <= NUM_SRC'(1) << w_winner;
            r_last_claim <= w_winner;
          end else if (!w_valid) begin
            r_state <= IDLE;
            r_meip  <= 1'b0;
          end
        end
        SERVICE: begin
          if (complete_i) begin
            r_state      <= IDLE;
            r_claim_id   <= '0;
            r_in_service <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_meip  <= 1'b0;
        end
      endcase
    end
  end

  assign meip_o     = r_meip;
  assign claim_id_o = r_claim_id;
  assign pending_o  = r_pending;

endmodule

// File: doc/irq_gateway.md
# irq_gateway

Parametrised external-interrupt gateway that sits between N peripheral interrupt lines and the core's single machine external interrupt input (meip). It latches per-source requests (level or edge mode), arbitrates among pending and enabled sources, drives meip toward the core, and runs a claim/complete handshake against the core's interrupt acknowledge. It supersedes the single-line meip wiring: it adds multiple channels, per-channel edge/level mode and a claim ID readable by the trap handler.

## Interface
- NUM_SRC, 8: number of interrupt sources, 1..31.
- ROUND_ROBIN, 0: 0 = fixed priority (lowest index wins); 1 = rotating priority starting after the last claimed source.
- ID_W, localparam = $clog2(NUM_SRC+1): claim ID width. ID 0 means "no source".

- clk_i  in  1  core clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- src_i  in  NUM_SRC  raw source lines, synchronous to clk_i.
- mode_i  in  NUM_SRC  per-source mode: 1 = rising-edge, 0 = level-high.
- enable_i  in  NUM_SRC  per-source enable mask.
- meip_o  out  1  interrupt request to the core.
- irq_ack_i  in  1  one-cycle pulse from the core on trap entry (irq_ack_o of core).
- claim_id_o  out  ID_W  ID (index+1) of the claimed source. 0 when none is claimed.
- complete_i  in  1  one-cycle pulse from the handler ending service of the claimed source.
- pending_o  out  NUM_SRC  pending register, for debug and CSR mirroring.

## Operation
- Gateway per source:
  - Edge mode: src_q holds the previous sample. src_i & ~src_q sets pending[i].
  - Level mode: pending[i] follows src_i, masked while source i is in service.
- Eligible vector: pending & enable_i & ~in_service_mask.
- Arbiter picks the winner from the eligible vector:
  - ROUND_ROBIN=0: lowest index.
  - ROUND_ROBIN=1: first eligible index after last_claim, wrapping modulo NUM_SRC.
- FSM states:
  - IDLE: if the eligible vector is nonzero, go to REQ.
  - REQ: meip_o=1. The winner is re-evaluated every cycle. If the eligible vector becomes 0 (level source dropped, or enable cleared), return to IDLE. On irq_ack_i:
    - latch the winner into claim_id_o;
    - clear pending of an edge-mode winner;
    - set in_service for that index;
    - update last_claim;
    - go to SERVICE.
  - SERVICE: meip_o=0. On complete_i, clear in_service and claim_id_o, then go to IDLE.
- Ignored events:
  - irq_ack_i outside REQ.
  - complete_i outside SERVICE.
- Simultaneous irq_ack_i and a pending-vector change in REQ: the winner registered in that cycle is claimed.
- An edge on the claimed source during SERVICE sets pending again. It is serviced after complete_i.
- A disabled source still accumulates pending. It requests as soon as it is enabled.

## Timing
- Reset values:
  - meip_o=0, claim_id_o=0, pending_o=0.
  - FSM state = IDLE, last_claim = NUM_SRC-1, src_q=0.
- Edge detection:
  - edge at cycle t → pending bit set at t+1;
  - IDLE→REQ at t+2;
  - meip_o is registered and high from t+2.
- Level source: src_i high at t → meip_o high at t+2.
- irq_ack_i at cycle a → claim_id_o valid and meip_o low from a+1.
- complete_i at cycle c → claim_id_o=0 at c+1.
  - If another source is eligible, meip_o rises at c+2. Minimum one-cycle meip_o low gap between services.
- Reset mid-operation (any state) immediately forces all reset values; pending edges are lost.

## Structure
- Shared package irq_pkg:
  - state enum {IDLE, REQ, SERVICE};
  - MAX_SRC=31;
  - function id_of(index) = index+1.
- One sub-module, irq_prio_arb. It is combinational: given the eligible vector, ROUND_ROBIN and last_claim, it outputs the winner index and a valid bit. The FSM, gateways and registers live in irq_gateway.

## Test plan
- Fixed priority: enable=8'hFF, edge mode, src[5] and src[2] pulse in the same cycle → meip_o high 2 cycles later.
  - irq_ack_i → claim_id_o=3.
  - complete_i → meip_o re-rises, irq_ack_i → claim_id_o=6.
- Round-robin (ROUND_ROBIN=1): sources 0, 1, 3 held high in level mode, three ack/complete rounds → claim_id_o sequence 1, 2, 4, then 1 again.
- Level drop in REQ: level src[4] high for 3 cycles then low before irq_ack_i → meip_o returns to 0. A late irq_ack_i leaves claim_id_o=0.
- Edge during service: claim source 0, pulse src[0] again during SERVICE → pending_o[0]=1. After complete_i, meip_o rises and the next claim returns 1.
- Masking: pulse src[7] with enable[7]=0 → meip_o stays 0 and pending_o[7]=1. Set enable[7]=1 → meip_o high next cycle.
- Reset in SERVICE: assert reset_i=0 mid-service → meip_o, claim_id_o, pending_o all 0 without a clock edge. Stray complete_i after release is ignored.
